// File: rtl/iu_pkg.sv
// Shared latency constants and types for the issue unit and its CDB booking table.
package iu_pkg;

    localparam int INT_LAT = 1;
    localparam int LS_LAT  = 1;
    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 7;

    function automatic int lat_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_LAT   = lat_max(lat_max(INT_LAT, LS_LAT), lat_max(MUL_LAT, DIV_LAT));
    localparam int DIV_CNT_W = $clog2(DIV_LAT);

    // Bit k refers to the CDB slot k cycles from now.
    typedef logic [MAX_LAT:1] slot_vec_t;

endpackage

// File: rtl/iu_cdb_booking.sv
// CDB booking table: a shift register of reserved future CDB slots.
module iu_cdb_booking
    import iu_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  slot_vec_t set,
    output slot_vec_t free
);

    slot_vec_t bk;

    // Every slot moves one cycle closer; new reservations land on top of the shifted view.
    always_ff @(posedge clk) begin
        if (reset) begin
            bk <= '0;
        end else begin
            bk <= {1'b0, bk[MAX_LAT:2]} | set;
        end
    end

    assign free = ~bk;

endmodule

// File: rtl/issue_unit.sv
// Issue arbiter for the int, load/store, mul and div queues; guarantees single-CDB writeback.
module issue_unit
    import iu_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic cdb_flush,
    input  logic iq_int_rdy,
    input  logic iq_ls_rdy,
    input  logic iq_mul_rdy,
    input  logic iq_div_rdy,
    output logic iu_int_en,
    output logic iu_ls_en,
    output logic iu_mul_en,
    output logic iu_div_en,
    output logic iu_div_busy
);

    slot_vec_t              free;
    slot_vec_t              set;
    logic                   lru;
    logic [DIV_CNT_W-1:0]   div_cnt;
    logic                   gate;
    logic                   tie;
    logic                   unused_free;

    iu_cdb_booking u_booking (
        .clk   (clk),
        .reset (reset),
        .set   (set),
        .free  (free)
    );

    assign unused_free = ^free;
    assign gate        = ~cdb_flush & ~reset;
    assign tie         = iq_int_rdy & iq_ls_rdy;

    assign iu_div_en = gate & iq_div_rdy & free[DIV_LAT] & (div_cnt == '0);
    assign iu_mul_en = gate & iq_mul_rdy & free[MUL_LAT];
    // A lone ready side wins outright; on a tie the lru side wins.
    assign iu_int_en = gate & free[INT_LAT] & iq_int_rdy & (~iq_ls_rdy | ~lru);
    assign iu_ls_en  = gate & free[LS_LAT]  & iq_ls_rdy  & (~iq_int_rdy | lru);

    // Latency-1 units write back next cycle and need no reservation.
    always_comb begin
        set = '0;
        for (int k = 1; k <= MAX_LAT; k++) begin
            if (INT_LAT - 1 == k) set[k] = set[k] | iu_int_en;
            if (LS_LAT  - 1 == k) set[k] = set[k] | iu_ls_en;
            if (MUL_LAT - 1 == k) set[k] = set[k] | iu_mul_en;
            if (DIV_LAT - 1 == k) set[k] = set[k] | iu_div_en;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lru     <= 1'b0;
            div_cnt <= '0;
        end else begin
            if (tie && (iu_int_en || iu_ls_en)) begin
                lru <= ~lru;
            end
            if (iu_div_en) begin
                div_cnt <= DIV_CNT_W'(DIV_LAT - 1);
            end else if (div_cnt != '0) begin
                div_cnt <= div_cnt - 1'b1;
            end
        end
    end

    assign iu_div_busy = (div_cnt != '0);

endmodule

// File: tb/tb_issue_unit.sv
// Directed scoreboard bench for issue_unit: driver queues expectations, monitor checks them.
module tb_issue_unit;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic cdb_flush = 1'b0;
    logic iq_int_rdy = 1'b0;
    logic iq_ls_rdy = 1'b0;
    logic iq_mul_rdy = 1'b0;
    logic iq_div_rdy = 1'b0;
    logic iu_int_en, iu_ls_en, iu_mul_en, iu_div_en, iu_div_busy;

    typedef struct {
        string      nm;
        logic [4:0] exp;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    issue_unit dut (
        .clk         (clk),
        .reset       (reset),
        .cdb_flush   (cdb_flush),
        .iq_int_rdy  (iq_int_rdy),
        .iq_ls_rdy   (iq_ls_rdy),
        .iq_mul_rdy  (iq_mul_rdy),
        .iq_div_rdy  (iq_div_rdy),
        .iu_int_en   (iu_int_en),
        .iu_ls_en    (iu_ls_en),
        .iu_mul_en   (iu_mul_en),
        .iu_div_en   (iu_div_en),
        .iu_div_busy (iu_div_busy)
    );

    always #5 clk = ~clk;

    // Monitor: one expected record per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [4:0] act;
            e   = sb.pop_front();
            act = {iu_int_en, iu_ls_en, iu_mul_en, iu_div_en, iu_div_busy};
            total++;
            if (act !== e.exp) begin
                bad++;
                $display("FAIL %s: got int/ls/mul/div/busy=%b want %b", e.nm, act, e.exp);
            end
        end
    end

    // exp bits: {int_en, ls_en, mul_en, div_en, div_busy}
    task automatic step(input string nm, input logic r, input logic f,
                        input logic ir, input logic lr, input logic mr, input logic dr,
                        input logic [4:0] exp);
        exp_t e;
        @(posedge clk);
        #1;
        reset      = r;
        cdb_flush  = f;
        iq_int_rdy = ir;
        iq_ls_rdy  = lr;
        iq_mul_rdy = mr;
        iq_div_rdy = dr;
        e.nm  = nm;
        e.exp = exp;
        sb.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        //     name          rst flush int ls mul div   int ls mul div busy
        step("reset_a",      1, 0, 1, 1, 1, 1, 5'b00000);
        step("reset_b",      1, 0, 1, 1, 1, 1, 5'b00000);
        step("idle",         0, 0, 0, 0, 0, 0, 5'b00000);
        step("tie_1",        0, 0, 1, 1, 0, 0, 5'b10000);
        step("tie_2",        0, 0, 1, 1, 0, 0, 5'b01000);
        step("tie_3",        0, 0, 1, 1, 0, 0, 5'b10000);
        step("tie_4",        0, 0, 1, 1, 0, 0, 5'b01000);
        step("mul_t0",       0, 0, 0, 0, 1, 0, 5'b00100);
        step("mul_int_t1",   0, 0, 1, 0, 0, 0, 5'b10000);
        step("mul_int_t2",   0, 0, 1, 0, 0, 0, 5'b10000);
        step("mul_int_t3",   0, 0, 1, 0, 0, 0, 5'b00000);
        step("mul_int_t4",   0, 0, 1, 0, 0, 0, 5'b10000);
        step("div_t0",       0, 0, 0, 0, 0, 1, 5'b00010);
        step("div_t1",       0, 0, 0, 0, 0, 1, 5'b00001);
        step("div_t2",       0, 0, 0, 0, 0, 1, 5'b00001);
        step("div_mul_t3",   0, 0, 0, 0, 1, 1, 5'b00001);
        step("div_t4",       0, 0, 0, 0, 0, 1, 5'b00001);
        step("div_t5",       0, 0, 0, 0, 0, 1, 5'b00001);
        step("div_t6",       0, 0, 0, 0, 0, 1, 5'b00001);
        step("div_t7",       0, 0, 0, 0, 0, 1, 5'b00010);
        step("div_rst_mid",  1, 0, 0, 0, 0, 1, 5'b00001);
        step("all_three",    0, 0, 1, 0, 1, 1, 5'b10110);
        step("bk_int_1",     0, 0, 1, 0, 0, 0, 5'b10001);
        step("bk_int_2",     0, 0, 1, 0, 0, 0, 5'b10001);
        step("bk_int_mul_3", 0, 0, 1, 0, 1, 0, 5'b00001);
        step("bk_int_4",     0, 0, 1, 0, 0, 0, 5'b10001);
        step("drain_5",      0, 0, 0, 0, 0, 0, 5'b00001);
        step("drain_6",      0, 0, 0, 0, 0, 0, 5'b00001);
        step("drain_7",      0, 0, 0, 0, 0, 0, 5'b00000);
        step("fl_mul",       0, 0, 0, 0, 1, 0, 5'b00100);
        step("fl_all",       0, 1, 1, 1, 1, 1, 5'b00000);
        step("fl_int_a2",    0, 0, 1, 0, 0, 0, 5'b10000);
        step("fl_int_a3",    0, 0, 1, 0, 0, 0, 5'b00000);
        step("fl_int_a4",    0, 0, 1, 0, 0, 0, 5'b10000);
        step("lru_tie_a",    0, 0, 1, 1, 0, 0, 5'b10000);
        step("lru_flush",    0, 1, 1, 1, 0, 0, 5'b00000);
        step("lru_tie_b",    0, 0, 1, 1, 0, 0, 5'b01000);
        step("solo_int",     0, 0, 1, 0, 0, 0, 5'b10000);
        step("solo_ls",      0, 0, 0, 1, 0, 0, 5'b01000);
        step("lru_tie_c",    0, 0, 1, 1, 0, 0, 5'b10000);
        step("end_idle",     0, 0, 0, 0, 0, 0, 5'b00000);
        @(posedge clk);
        @(negedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
